// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared constants and types for the button input conditioning stage.
//   BUTTON_COUNT           : number of board buttons feeding the counter
//   DEBOUNCE_CYCLES_SIM    : short debounce window for simulation
//   DEBOUNCE_CYCLES_BOARD  : 20 ms at 50 MHz
//   REPEAT_*_DEFAULT       : auto-repeat timing used when
//                            BUTTON_CONDITIONER_AUTO_REPEAT_EN is defined
// -----------------------------------------------------------------------------
package button_pkg;

    localparam int BUTTON_COUNT          = 3;
    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 1_000_000;
    localparam int REPEAT_DELAY_DEFAULT  = 8;
    localparam int REPEAT_PERIOD_DEFAULT = 3;

    // What the debounce counter does on the next edge.
    typedef enum logic [1:0] {
        DB_IDLE   = 2'd0,   // synchronised input agrees with level
        DB_COUNT  = 2'd1,   // disagreement persists, keep counting
        DB_ACCEPT = 2'd2    // disagreement lasted long enough, take it
    } db_action_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button channel: 2-flop synchroniser, stable-cycle counter, registered
// debounced level and a registered one-cycle press pulse on each accepted
// 0->1 level change. With BUTTON_CONDITIONER_AUTO_REPEAT_EN defined, a held
// button also produces repeat pulses REPEAT_DELAY cycles after the press and
// every REPEAT_PERIOD cycles thereafter.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   button : raw asynchronous button level
//   level  : debounced level
//   press  : one-cycle pulse per accepted press (plus repeats if enabled)
// -----------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;  // level one cycle late, for edge detect
    logic             press_q, press_d;
    logic             rise;
    db_action_e       action;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [REP_W-1:0] rep_q, rep_d;
    // 0: waiting out the initial delay, 1: in the periodic phase
    logic             rep_periodic_q, rep_periodic_d;
    logic [REP_W-1:0] rep_limit;
`endif

    // Counter never passes CNT_LAST: it clears on agreement or on acceptance.
    always_comb begin
        if (s2_q == level_q) begin
            action = DB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
            action = DB_ACCEPT;
        end else begin
            action = DB_COUNT;
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        s1_d        = button;
        s2_d        = s1_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        level_dly_d = level_q;

        unique case (action)
            DB_IDLE:   cnt_d = '0;
            DB_ACCEPT: begin
                level_d = s2_q;
                cnt_d   = '0;
            end
            default:   cnt_d = cnt_q + CNT_W'(1);
        endcase

        // level_q rose on the previous edge; registering this gives a press
        // one cycle after the level update.
        rise    = level_q & ~level_dly_q;
        press_d = rise;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        rep_d          = rep_q;
        rep_periodic_d = rep_periodic_q;
        rep_limit      = rep_periodic_q ? REP_W'(REPEAT_PERIOD - 1)
                                        : REP_W'(REPEAT_DELAY - 1);
        if (rise) begin
            rep_d          = '0;
            rep_periodic_d = 1'b0;
        end else if (level_q) begin
            // rep_q counts cycles since the last pulse; it is cleared on
            // every pulse so it cannot exceed rep_limit.
            if (rep_q == rep_limit) begin
                press_d        = 1'b1;
                rep_d          = '0;
                rep_periodic_d = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end else begin
            rep_d          = '0;
            rep_periodic_d = 1'b0;
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments so all flops
    // sample their _d values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
        end
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q          <= '0;
            rep_periodic_q <= 1'b0;
        end else begin
            rep_q          <= rep_d;
            rep_periodic_q <= rep_periodic_d;
        end
    end
`endif

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronises and debounces WIDTH independent raw buttons for the press
// counter. Optional auto-repeat: define BUTTON_CONDITIONER_AUTO_REPEAT_EN.
// Ports:
//   clk     : clock (50 MHz on board)
//   rst     : synchronous active-high reset
//   buttons : raw asynchronous button levels, active-high
//   level   : debounced button state
//   press   : one-cycle pulse per accepted press (plus repeats if enabled)
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int WIDTH           = BUTTON_COUNT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] buttons,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .button (buttons[i]),
            .level  (level[i]),
            .press  (press[i])
        );
    end

endmodule
